// File: rtl/vga_fb_pkg.sv
// Shared types and helpers for the scaled VGA frame-buffer reader.
// Display modes, default VGA/QVGA geometry and pixel-format conversion.
// No timing or flow control lives here.
package vga_fb_pkg;

  typedef enum logic [1:0] {
    MODE_1X_TL  = 2'd0,
    MODE_2X     = 2'd1,
    MODE_1X_CTR = 2'd2
  } scale_mode_e;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_V_VISIBLE = 480;
  localparam int QVGA_W        = 320;
  localparam int QVGA_H        = 240;

  // The reserved encoding falls back to top-left 1x.
  function automatic scale_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_2X;
      2'd2:    return MODE_1X_CTR;
      default: return MODE_1X_TL;
    endcase
  endfunction

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register for aligning side-band bits with a read pipeline.
// Latency: DEPTH clocks from din to dout.
// Backpressure: none, advances every clock.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader_scaled.sv
// Frame-buffer reader with 1x top-left, 1x centred and 2x upscale modes.
// Latency: x/y to rAddr 1 clock, x/y to RGB and delayed syncs RD_LAT+2 clocks.
// Backpressure: none, one pixel per clock; frame buffer must keep up.
module vga_fb_reader_scaled
  import vga_fb_pkg::*;
#(
  parameter int SRC_W    = QVGA_W,
  parameter int SRC_H    = QVGA_H,
  parameter int SCREEN_W = VGA_H_VISIBLE,
  parameter int SCREEN_H = VGA_V_VISIBLE,
  parameter int ADDR_W   = 17,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        scale_mode,
  input  logic              DE,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  output logic              den,
  output logic [ADDR_W-1:0] rAddr,
  input  logic [15:0]       rData,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              de_out
);

  localparam int X_OFF = (SCREEN_W - SRC_W) / 2;
  localparam int Y_OFF = (SCREEN_H - SRC_H) / 2;
  localparam int CW    = 12;

  localparam logic [CW-1:0] SW_1X = CW'(SRC_W);
  localparam logic [CW-1:0] SH_1X = CW'(SRC_H);
  localparam logic [CW-1:0] SW_2X = CW'(2 * SRC_W);
  localparam logic [CW-1:0] SH_2X = CW'(2 * SRC_H);
  localparam logic [CW-1:0] X_LO  = CW'(X_OFF);
  localparam logic [CW-1:0] X_HI  = CW'(X_OFF + SRC_W);
  localparam logic [CW-1:0] Y_LO  = CW'(Y_OFF);
  localparam logic [CW-1:0] Y_HI  = CW'(Y_OFF + SRC_H);
  localparam logic [CW-1:0] X_END = CW'(SCREEN_W - 1);
  localparam logic [CW-1:0] Y_END = CW'(SCREEN_H - 1);

  scale_mode_e       mode_q;
  logic [ADDR_W-1:0] line_base;
  logic [CW-1:0]     xe, ye, src_col;
  logic              x_ok, y_ok, row_adv, in_win, line_end;
  logic [3:0]        tap;

  assign xe = CW'(x_pixel);
  assign ye = CW'(y_pixel);

  always_comb begin
    x_ok    = 1'b0;
    y_ok    = 1'b0;
    src_col = xe;
    row_adv = 1'b0;
    case (mode_q)
      MODE_2X: begin
        x_ok    = xe < SW_2X;
        y_ok    = ye < SH_2X;
        src_col = xe >> 1;
        // each source row is shown on two display lines
        row_adv = y_ok & ye[0];
      end
      MODE_1X_CTR: begin
        x_ok    = (xe >= X_LO) && (xe < X_HI);
        y_ok    = (ye >= Y_LO) && (ye < Y_HI);
        src_col = xe - X_LO;
        row_adv = y_ok;
      end
      default: begin
        x_ok    = xe < SW_1X;
        y_ok    = ye < SH_1X;
        row_adv = y_ok;
      end
    endcase
  end

  assign in_win   = DE & x_ok & y_ok;
  assign line_end = DE && (xe == X_END);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      den       <= 1'b0;
      rAddr     <= '0;
      line_base <= '0;
    end else begin
      den <= in_win;
      if (in_win) rAddr <= line_base + ADDR_W'(src_col);
      if (line_end) begin
        if (ye == Y_END)  line_base <= '0;
        else if (row_adv) line_base <= line_base + ADDR_W'(SRC_W);
      end
    end
  end

  // Mode is sampled only at frame boundaries so a frame never mixes modes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= decode_mode(scale_mode);
    end else if (line_end && (ye == Y_END)) begin
      mode_q <= decode_mode(scale_mode);
    end
  end

  vga_delay_line #(.WIDTH(4), .DEPTH(RD_LAT + 1)) u_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({in_win, DE, hsync_in, vsync_in}),
    .dout  (tap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_port, g_port, b_port} <= 12'h000;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      {r_port, g_port, b_port} <= tap[3] ? rgb565_to_444(rData) : 12'h000;
      de_out    <= tap[2];
      hsync_out <= tap[1];
      vsync_out <= tap[0];
    end
  end

endmodule

// File: tb/tb_vga_fb_reader_scaled.sv
// Directed bench: RD_LAT=1 instance with address-echo memory, RD_LAT=3 instance
// with constant read data, both driven by the same sparse frame stimulus.
module tb_vga_fb_reader_scaled;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  scale_mode;
  logic        de, hs, vs;
  logic [9:0]  xp, yp;

  logic        den1, den3;
  logic [16:0] raddr1, raddr3;
  logic [15:0] rdata1;
  logic [15:0] rdata3;
  logic [3:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, deo1, hs3, vs3, deo3;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // single-cycle read memory returning its own address
  always @(posedge clk) rdata1 <= raddr1[15:0];
  assign rdata3 = 16'hF81F;

  vga_fb_reader_scaled #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .scale_mode(scale_mode), .DE(de),
    .hsync_in(hs), .vsync_in(vs), .x_pixel(xp), .y_pixel(yp),
    .den(den1), .rAddr(raddr1), .rData(rdata1),
    .r_port(r1), .g_port(g1), .b_port(b1),
    .hsync_out(hs1), .vsync_out(vs1), .de_out(deo1)
  );

  vga_fb_reader_scaled #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .scale_mode(scale_mode), .DE(de),
    .hsync_in(hs), .vsync_in(vs), .x_pixel(xp), .y_pixel(yp),
    .den(den3), .rAddr(raddr3), .rData(rdata3),
    .r_port(r3), .g_port(g3), .b_port(b3),
    .hsync_out(hs3), .vsync_out(vs3), .de_out(deo3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One active pixel, then idle; checks den/rAddr after 1 clock and RGB after 3.
  task automatic probe(input string tag, input int x, input int y,
                       input logic exp_den, input int exp_addr, input logic [11:0] exp_rgb);
    @(negedge clk); de = 1'b1; xp = 10'(x); yp = 10'(y);
    @(negedge clk); de = 1'b0;
    check({tag, "/den"}, 32'(den1), 32'(exp_den));
    if (exp_den) check({tag, "/addr"}, 32'(raddr1), 32'(exp_addr));
    repeat (2) @(negedge clk);
    check({tag, "/rgb"}, 32'({r1, g1, b1}), 32'(exp_rgb));
    check({tag, "/de_out"}, 32'(deo1), 32'd1);
  endtask

  task automatic eol(input int y);
    @(negedge clk); de = 1'b1; xp = 10'd639; yp = 10'(y);
    @(negedge clk); de = 1'b0;
  endtask

  task automatic eol_range(input int y0, input int y1);
    for (int y = y0; y <= y1; y++) eol(y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; scale_mode = 2'd3; de = 1'b0; hs = 1'b0; vs = 1'b0; xp = '0; yp = '0;
    #1;
    check("rst/den", 32'(den1), 32'd0);
    check("rst/addr", 32'(raddr1), 32'd0);
    check("rst/rgb", 32'({r1, g1, b1}), 32'h000);
    check("rst/syncs", 32'({hs3, vs3, deo3}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // frame A: mode 0 (reserved encoding at reset)
    probe("m0_320_0", 320, 0, 1'b0, 0, 12'h000);
    eol_range(0, 1);
    // (5,2): latency and sync alignment for both read latencies
    @(negedge clk); de = 1'b1; hs = 1'b1; xp = 10'd5; yp = 10'd2;
    @(negedge clk); de = 1'b0; hs = 1'b0; vs = 1'b1;
    check("m0_5_2/den", 32'(den1), 32'd1);
    check("m0_5_2/addr", 32'(raddr1), 32'd645);
    check("lat3/addr", 32'(raddr3), 32'd645);
    @(negedge clk); vs = 1'b0;
    check("m0_5_2/rgb_early", 32'({r1, g1, b1}), 32'h000);
    @(negedge clk);
    check("m0_5_2/rgb", 32'({r1, g1, b1}), 32'h052);
    check("lat1/syncs", 32'({deo1, hs1, vs1}), 32'b110);
    @(negedge clk);
    check("lat3/syncs_e4", 32'({deo3, hs3, vs3}), 32'b000);
    @(negedge clk);
    check("lat3/syncs_e5", 32'({deo3, hs3, vs3}), 32'b110);
    check("lat3/rgb_e5", 32'({r3, g3, b3}), 32'hF0F);
    @(negedge clk);
    check("lat3/syncs_e6", 32'({deo3, hs3, vs3}), 32'b001);
    check("lat3/rgb_e6", 32'({r3, g3, b3}), 32'h000);

    eol(2);
    scale_mode = 2'd1;  // requested mid-frame, must wait for frame end
    probe("m0_5_3_pending", 5, 3, 1'b1, 965, 12'h072);
    eol_range(3, 239);
    probe("m0_0_240", 0, 240, 1'b0, 0, 12'h000);
    eol_range(240, 479);

    // frame B: mode 1
    probe("m1_0_0", 0, 0, 1'b1, 0, 12'h000);
    probe("m1_1_0", 1, 0, 1'b1, 0, 12'h000);
    eol(0);
    probe("m1_2_1", 2, 1, 1'b1, 1, 12'h000);
    eol(1);
    probe("m1_0_2", 0, 2, 1'b1, 320, 12'h020);
    eol_range(2, 478);
    scale_mode = 2'd2;
    probe("m1_639_479", 639, 479, 1'b1, 76799, 12'h27F);

    // frame C: mode 2 (centred)
    eol_range(0, 119);
    probe("m2_159_120", 159, 120, 1'b0, 0, 12'h000);
    probe("m2_160_120", 160, 120, 1'b1, 0, 12'h000);
    eol_range(120, 199);
    probe("m2_480_200", 480, 200, 1'b0, 0, 12'h000);
    eol_range(200, 358);
    probe("m2_479_359", 479, 359, 1'b1, 76799, 12'h27F);
    scale_mode = 2'd3;
    eol_range(359, 479);

    // frame D: reserved mode behaves as mode 0
    eol_range(0, 1);
    probe("m3_5_2", 5, 2, 1'b1, 645, 12'h052);

    // async reset mid-line with a live pixel in flight
    @(negedge clk); de = 1'b1; xp = 10'd6; yp = 10'd2;
    repeat (3) @(negedge clk);
    check("pre_rst/addr", 32'(raddr1), 32'd646);
    check("pre_rst/rgb", 32'({r1, g1, b1}), 32'h053);
    #1 reset = 1'b1;
    #1;
    check("async_rst/den", 32'(den1), 32'd0);
    check("async_rst/addr", 32'(raddr1), 32'd0);
    check("async_rst/rgb", 32'({r1, g1, b1}), 32'h000);
    check("async_rst/de_out", 32'(deo1), 32'd0);
    @(negedge clk); reset = 1'b0; de = 1'b0;
    probe("post_rst_5_3", 5, 3, 1'b1, 5, 12'h002);
    eol_range(3, 479);
    eol_range(0, 1);
    probe("post_rst_5_2", 5, 2, 1'b1, 645, 12'h052);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
